qdq_scale_pairer: RTL and testbench
===================================

Name: qdq_scale_pairer

Overview:
Parametrised successor to the fixed one-to-one scale-hold logic in the QDQ controller. It buffers A-side and B-side per-row scale vectors from the two quantize arrays in independent FIFOs. It pairs them according to a programmable reuse mode (one-to-one, A-reuse, B-reuse) and emits registered pairs, each with a tile tag and a group-last flag. The output feeds scale_cross_product and scale_fifo, so K/N-tiled GEMM schedules can reuse a scale vector without re-quantizing.

Parameters:
MAT_SIZE, 16, elements per scale vector
FP_MANT_W, 23, mantissa width per element
FP_EXP_W, 8, raw exponent width per element
A_DEPTH, 4, A-side FIFO entries (power of 2, >=2)
B_DEPTH, 4, B-side FIFO entries (power of 2, >=2)
CNT_W, 8, reuse-count width
TAG_W, 8, tile-tag width

Ports:
clk  in  1  clock, all logic on rising edge
rstnn  in  1  reset; synchronous, active-high (name kept from codebase)
clear_i  in  1  synchronous flush of FIFOs, counters, output stage
cfg_load_i  in  1  latch cfg_mode_i/cfg_reuse_i
cfg_mode_i  in  2  0=ONE2ONE, 1=A_REUSE, 2=B_REUSE, 3=reserved(as 0)
cfg_reuse_i  in  CNT_W  pairs per reused vector (0 treated as 1)
cfg_rej_o  out  1  1-cycle pulse: cfg_load_i ignored (not idle)
a_scl_valid_i  in  1  A scale vector valid
a_scl_ready_o  out  1  A FIFO not full
a_mant_i  in  FP_MANT_W*MAT_SIZE  A mantissa vector
a_exp_i  in  FP_EXP_W*MAT_SIZE  A exponent vector
b_scl_valid_i / b_scl_ready_o / b_mant_i / b_exp_i  as A side
m_valid_o  out  1  pair valid
m_ready_i  in  1  downstream accept
m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o  out  vector widths  paired scales
m_tag_o  out  TAG_W  pair sequence number
m_last_o  out  1  pair consumes the reused vector (end of group)
busy_o  out  1  any FIFO non-empty, output valid, or reuse count nonzero

Behaviour:
- Reset (rstnn=1 at edge): FIFOs empty, ready outputs 0 while rstnn high, m_valid_o=0, all data/tag outputs 0, m_last_o=0, cfg_rej_o=0, busy_o=0. Mode=ONE2ONE, reuse=1, reuse count=0.
- Priority: rstnn > clear_i > normal operation. clear_i empties both FIFOs, drops m_valid_o, zeroes tag and reuse count. Config is kept. Pushes in the clear cycle are discarded.
- FIFO: show-ahead, push when valid&ready. ready = not full; there is no pass-through when full, even if a pop happens in the same cycle. Push+pop in the same cycle keeps the count.
- Output stage: single register. load_en = A head valid & B head valid & (!m_valid_o | m_ready_i). Latency from both heads valid to m_valid_o = 1 cycle. Outputs are held stable while m_valid_o & !m_ready_i. Back-to-back pairs at 1/cycle.
- On load_en, with R = max(reuse,1) and counter c:
  - ONE2ONE: pop A and B; m_last_o=1.
  - A_REUSE: pop B. If c==R-1, pop A, c<=0, m_last_o=1; else c<=c+1, m_last_o=0.
  - B_REUSE: symmetric, with A popped every pair.
- m_tag_o increments by 1 per loaded pair and wraps modulo 2^TAG_W. The first pair after reset/clear carries tag 0.
- cfg_load_i is accepted only when idle (FIFOs empty, !m_valid_o, c==0). Otherwise it is ignored and cfg_rej_o pulses next cycle. The new config applies from the next load.
- cfg_load_i together with clear_i: clear first, then the load is accepted.
- Exponents and mantissas are passed through unmodified; no arithmetic in this block.

Test Plan:
- ONE2ONE: push A0..A3 and B0..B3 with m_ready_i=1 -> 4 pairs (Ai,Bi), tags 0..3, m_last_o=1 each, first m_valid_o 1 cycle after both heads valid.
- A_REUSE, reuse=3: push A0,A1 and B0..B5 -> pairs (A0,B0)(A0,B1)(A0,B2)(A1,B3)(A1,B4)(A1,B5); m_last_o on 3rd and 6th pair.
- Backpressure: m_ready_i=0 for 5 cycles with A_DEPTH=4 and 6 A pushes -> outputs stable, a_scl_ready_o=0 once the FIFO holds 4 entries, no pushes lost after release.
- cfg_load_i while busy -> cfg_rej_o pulses once and the mode is unchanged; cfg_load_i when idle with reuse=0 -> behaves as reuse=1.
- clear_i mid-group (A_REUSE, c=1, 2 entries queued) -> next cycle m_valid_o=0, busy_o=0; next pair tag 0 and group restarts.
- Tag wrap with TAG_W=2: 5 pairs -> tags 0,1,2,3,0.

Source files
------------

// File: rtl/qdq_scale_pairer.sv
// qdq_scale_pairer: buffers A/B scale vectors in FIFOs and emits registered pairs,
// optionally reusing one side's vector for a programmable number of pairs.
module qdq_scale_pairer #(
  parameter int MAT_SIZE  = 16,
  parameter int FP_MANT_W = 23,
  parameter int FP_EXP_W  = 8,
  parameter int A_DEPTH   = 4,
  parameter int B_DEPTH   = 4,
  parameter int CNT_W     = 8,
  parameter int TAG_W     = 8
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          clear_i,
  input  logic                          cfg_load_i,
  input  logic [1:0]                    cfg_mode_i,
  input  logic [CNT_W-1:0]              cfg_reuse_i,
  output logic                          cfg_rej_o,
  input  logic                          a_scl_valid_i,
  output logic                          a_scl_ready_o,
  input  logic [FP_MANT_W*MAT_SIZE-1:0] a_mant_i,
  input  logic [FP_EXP_W*MAT_SIZE-1:0]  a_exp_i,
  input  logic                          b_scl_valid_i,
  output logic                          b_scl_ready_o,
  input  logic [FP_MANT_W*MAT_SIZE-1:0] b_mant_i,
  input  logic [FP_EXP_W*MAT_SIZE-1:0]  b_exp_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [FP_MANT_W*MAT_SIZE-1:0] m_a_mant_o,
  output logic [FP_EXP_W*MAT_SIZE-1:0]  m_a_exp_o,
  output logic [FP_MANT_W*MAT_SIZE-1:0] m_b_mant_o,
  output logic [FP_EXP_W*MAT_SIZE-1:0]  m_b_exp_o,
  output logic [TAG_W-1:0]              m_tag_o,
  output logic                          m_last_o,
  output logic                          busy_o
);
  localparam int VM = FP_MANT_W * MAT_SIZE;
  localparam int VE = FP_EXP_W * MAT_SIZE;
  localparam int AW = $clog2(A_DEPTH);
  localparam int BW = $clog2(B_DEPTH);

  logic [VM+VE-1:0] r_a_mem [A_DEPTH];
  logic [VM+VE-1:0] r_b_mem [B_DEPTH];
  logic [AW-1:0]    r_a_wp, r_a_rp;
  logic [BW-1:0]    r_b_wp, r_b_rp;
  logic [AW:0]      r_a_cnt;
  logic [BW:0]      r_b_cnt;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_reuse, r_cnt;
  logic [TAG_W-1:0] r_tag;

  logic w_a_ne, w_b_ne, w_a_push, w_b_push, w_a_pop, w_b_pop, w_load;
  logic w_a_reuse, w_b_reuse, w_cend, w_last, w_idle;
  logic [CNT_W-1:0] w_r;
  logic [VM+VE-1:0] w_a_head, w_b_head;

  assign w_a_ne        = r_a_cnt != '0;
  assign w_b_ne        = r_b_cnt != '0;
  assign a_scl_ready_o = !rstnn && r_a_cnt != (AW+1)'(A_DEPTH);
  assign b_scl_ready_o = !rstnn && r_b_cnt != (BW+1)'(B_DEPTH);
  assign w_a_push      = a_scl_valid_i && a_scl_ready_o;
  assign w_b_push      = b_scl_valid_i && b_scl_ready_o;
  assign w_a_head      = r_a_mem[r_a_rp];
  assign w_b_head      = r_b_mem[r_b_rp];
  assign w_load        = w_a_ne && w_b_ne && (!m_valid_o || m_ready_i);
  assign w_r           = r_reuse == '0 ? CNT_W'(1) : r_reuse;
  assign w_cend        = r_cnt == w_r - 1'b1;
  // reserved mode 3 falls through to one-to-one because neither reuse flag is set
  assign w_a_reuse     = r_mode == 2'd1;
  assign w_b_reuse     = r_mode == 2'd2;
  assign w_a_pop       = w_load && (!w_a_reuse || w_cend);
  assign w_b_pop       = w_load && (!w_b_reuse || w_cend);
  assign w_last        = !(w_a_reuse || w_b_reuse) || w_cend;
  assign w_idle        = !w_a_ne && !w_b_ne && !m_valid_o && r_cnt == '0;
  assign busy_o        = w_a_ne || w_b_ne || m_valid_o || r_cnt != '0;

  always_ff @(posedge clk) begin
    if (w_a_push && !clear_i) r_a_mem[r_a_wp] <= {a_mant_i, a_exp_i};
    if (w_b_push && !clear_i) r_b_mem[r_b_wp] <= {b_mant_i, b_exp_i};
  end

  always_ff @(posedge clk) begin
    if (rstnn) begin
      r_a_wp <= '0; r_a_rp <= '0; r_a_cnt <= '0;
      r_b_wp <= '0; r_b_rp <= '0; r_b_cnt <= '0;
      r_mode <= 2'd0; r_reuse <= CNT_W'(1); r_cnt <= '0; r_tag <= '0;
      m_valid_o <= 1'b0; m_last_o <= 1'b0; m_tag_o <= '0; cfg_rej_o <= 1'b0;
      m_a_mant_o <= '0; m_a_exp_o <= '0; m_b_mant_o <= '0; m_b_exp_o <= '0;
    end else begin
      cfg_rej_o <= cfg_load_i && !clear_i && !w_idle;
      if (cfg_load_i && (clear_i || w_idle)) begin
        r_mode  <= cfg_mode_i;
        r_reuse <= cfg_reuse_i;
      end
      if (clear_i) begin
        r_a_wp <= '0; r_a_rp <= '0; r_a_cnt <= '0;
        r_b_wp <= '0; r_b_rp <= '0; r_b_cnt <= '0;
        r_cnt <= '0; r_tag <= '0; m_tag_o <= '0; m_valid_o <= 1'b0;
      end else begin
        if (w_a_push) r_a_wp <= r_a_wp + 1'b1;
        if (w_b_push) r_b_wp <= r_b_wp + 1'b1;
        if (w_a_pop) r_a_rp <= r_a_rp + 1'b1;
        if (w_b_pop) r_b_rp <= r_b_rp + 1'b1;
        r_a_cnt <= r_a_cnt + (AW+1)'(w_a_push) - (AW+1)'(w_a_pop);
        r_b_cnt <= r_b_cnt + (BW+1)'(w_b_push) - (BW+1)'(w_b_pop);
        if (w_load) begin
          m_valid_o  <= 1'b1;
          m_a_mant_o <= w_a_head[VM+VE-1:VE];
          m_a_exp_o  <= w_a_head[VE-1:0];
          m_b_mant_o <= w_b_head[VM+VE-1:VE];
          m_b_exp_o  <= w_b_head[VE-1:0];
          m_last_o   <= w_last;
          m_tag_o    <= r_tag;
          r_tag      <= r_tag + 1'b1;
          r_cnt      <= (w_a_reuse || w_b_reuse) && !w_cend ? r_cnt + 1'b1 : '0;
        end else if (m_ready_i) begin
          m_valid_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_qdq_scale_pairer.sv
// tb_qdq_scale_pairer: randomized scenarios checked against an index-arithmetic pairing model.
module tb_qdq_scale_pairer;
  localparam int MS = 4, MW = 23, EW = 8, TW = 2, CW = 8;
  localparam int VM = MW * MS, VE = EW * MS;

  typedef struct packed { logic [VM-1:0] m; logic [VE-1:0] e; } vec_t;
  typedef struct packed { vec_t a; vec_t b; logic [TW-1:0] tag; logic last; } pair_t;

  logic clk = 1'b0, rstnn = 1'b1, clear_i = 1'b0, cfg_load_i = 1'b0;
  logic [1:0] cfg_mode_i = 2'd0;
  logic [CW-1:0] cfg_reuse_i = '0;
  logic cfg_rej_o, a_scl_ready_o, b_scl_ready_o, m_valid_o, m_last_o, busy_o;
  logic a_scl_valid_i = 1'b0, b_scl_valid_i = 1'b0, m_ready_i = 1'b0;
  logic [VM-1:0] a_mant_i = '0, b_mant_i = '0, m_a_mant_o, m_b_mant_o;
  logic [VE-1:0] a_exp_i = '0, b_exp_i = '0, m_a_exp_o, m_b_exp_o;
  logic [TW-1:0] m_tag_o;

  vec_t a_tx[$], b_tx[$];
  pair_t got[$];
  int ai, bi, tag_base, rdy_mode, n_chk, n_fail;

  qdq_scale_pairer #(.MAT_SIZE(MS), .FP_MANT_W(MW), .FP_EXP_W(EW), .A_DEPTH(4), .B_DEPTH(4),
    .CNT_W(CW), .TAG_W(TW)) dut (
    .clk(clk), .rstnn(rstnn), .clear_i(clear_i), .cfg_load_i(cfg_load_i),
    .cfg_mode_i(cfg_mode_i), .cfg_reuse_i(cfg_reuse_i), .cfg_rej_o(cfg_rej_o),
    .a_scl_valid_i(a_scl_valid_i), .a_scl_ready_o(a_scl_ready_o), .a_mant_i(a_mant_i), .a_exp_i(a_exp_i),
    .b_scl_valid_i(b_scl_valid_i), .b_scl_ready_o(b_scl_ready_o), .b_mant_i(b_mant_i), .b_exp_i(b_exp_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_a_mant_o(m_a_mant_o), .m_a_exp_o(m_a_exp_o),
    .m_b_mant_o(m_b_mant_o), .m_b_exp_o(m_b_exp_o), .m_tag_o(m_tag_o), .m_last_o(m_last_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (m_valid_o && m_ready_i && !rstnn && !clear_i)
      got.push_back('{a: '{m: m_a_mant_o, e: m_a_exp_o}, b: '{m: m_b_mant_o, e: m_b_exp_o}, tag: m_tag_o, last: m_last_o});

  function automatic vec_t rnd_vec();
    rnd_vec.m = VM'({$urandom, $urandom, $urandom});
    rnd_vec.e = VE'($urandom);
  endfunction

  task automatic new_test(int na, int nb);
    a_tx.delete(); b_tx.delete(); got.delete(); ai = 0; bi = 0;
    for (int i = 0; i < na; i++) a_tx.push_back(rnd_vec());
    for (int i = 0; i < nb; i++) b_tx.push_back(rnd_vec());
  endtask

  task automatic step();
    a_scl_valid_i = ai < a_tx.size();
    b_scl_valid_i = bi < b_tx.size();
    if (a_scl_valid_i) begin a_mant_i = a_tx[ai].m; a_exp_i = a_tx[ai].e; end
    if (b_scl_valid_i) begin b_mant_i = b_tx[bi].m; b_exp_i = b_tx[bi].e; end
    m_ready_i = rdy_mode == 2 ? 1'($urandom % 2) : rdy_mode[0];
    @(negedge clk);
    if (a_scl_valid_i && a_scl_ready_o && !clear_i) ai++;
    if (b_scl_valid_i && b_scl_ready_o && !clear_i) bi++;
    @(posedge clk); #1;
  endtask

  task automatic cfg(int mode, int reuse, bit clr);
    a_scl_valid_i = 1'b0; b_scl_valid_i = 1'b0;
    cfg_load_i = 1'b1; cfg_mode_i = 2'(mode); cfg_reuse_i = CW'(reuse); clear_i = clr;
    @(posedge clk); #1;
    cfg_load_i = 1'b0; clear_i = 1'b0;
    if (clr) tag_base = 0;
  endtask

  // Pair k takes A[k] or A[k/r] (A reused) and B[k] or B[k/r] (B reused); tags count from tag_base.
  task automatic check_pairs(string nm, int mode, int r);
    int np;
    pair_t e;
    np = mode == 1 ? b_tx.size() : mode == 2 ? a_tx.size() : (a_tx.size() < b_tx.size() ? a_tx.size() : b_tx.size());
    for (int i = 0; i < 300 && (got.size() < np || ai < a_tx.size() || bi < b_tx.size()); i++) step();
    repeat (4) step();
    n_chk++;
    if (got.size() !== np) begin
      n_fail++;
      $display("FAIL %s count: got %0d pairs, expected %0d", nm, got.size(), np);
    end
    for (int k = 0; k < np && k < got.size(); k++) begin
      e.a = mode == 1 ? a_tx[k / r] : a_tx[k];
      e.b = mode == 2 ? b_tx[k / r] : b_tx[k];
      e.tag = TW'(tag_base + k);
      e.last = (mode == 1 || mode == 2) ? (k % r == r - 1) : 1'b1;
      n_chk++;
      if (got[k] !== e) begin
        n_fail++;
        $display("FAIL %s pair %0d: got %h tag %0d last %0d, expected %h tag %0d last %0d",
                 nm, k, {got[k].a, got[k].b}, got[k].tag, got[k].last, {e.a, e.b}, e.tag, e.last);
      end
    end
    tag_base += np;
  endtask

  task automatic expect1(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    rstnn = 1'b1; a_scl_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 expect1("ready_in_reset", {b_scl_ready_o, a_scl_ready_o}, 0);
    a_scl_valid_i = 1'b0; rstnn = 1'b0;
    #1;
    expect1("reset_valid", m_valid_o, 0);
    expect1("reset_busy", busy_o, 0);
    expect1("reset_rej_last_tag", {cfg_rej_o, m_last_o, m_tag_o}, 0);
    expect1("reset_data", (|m_a_mant_o) | (|m_b_exp_o), 0);
    expect1("ready_after_reset", {b_scl_ready_o, a_scl_ready_o}, 3);
    tag_base = 0;
  endtask

  task automatic test_one2one();
    new_test(4, 4); rdy_mode = 1;
    step();
    expect1("latency_not_early", m_valid_o, 0);
    step();
    expect1("latency_one_cycle", m_valid_o, 1);
    check_pairs("one2one", 0, 1);
  endtask

  task automatic test_a_reuse();
    cfg(1, 3, 0); new_test(2, 6); rdy_mode = 2;
    check_pairs("a_reuse", 1, 3);
  endtask

  task automatic test_b_reuse();
    cfg(2, 2, 0); new_test(4, 2); rdy_mode = 2;
    check_pairs("b_reuse", 2, 2);
  endtask

  task automatic test_backpressure();
    logic [2*(VM+VE)-1:0] held;
    cfg(0, 1, 0); new_test(6, 6); rdy_mode = 0;
    step(); step();
    held = {m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o};
    expect1("bp_valid", m_valid_o, 1);
    repeat (4) step();
    expect1("bp_a_full", a_scl_ready_o, 0);
    expect1("bp_a_accepted", ai, 5);
    n_chk++;
    if ({m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o} !== held) begin
      n_fail++;
      $display("FAIL bp_stable: got %h, expected %h", {m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o}, held);
    end
    rdy_mode = 1;
    check_pairs("backpressure", 0, 1);
  endtask

  task automatic test_cfg_reject();
    cfg(1, 2, 0); new_test(1, 1); rdy_mode = 0;
    step(); step();
    cfg(0, 1, 0);
    expect1("rej_pulse", cfg_rej_o, 1);
    step();
    expect1("rej_one_cycle", cfg_rej_o, 0);
    b_tx.push_back(rnd_vec()); rdy_mode = 1;
    check_pairs("rej_mode_kept", 1, 2);
    cfg(1, 0, 0);
    expect1("idle_load_accepted", cfg_rej_o, 0);
    new_test(3, 3); rdy_mode = 2;
    check_pairs("reuse_zero", 1, 1);
  endtask

  task automatic test_clear();
    cfg(1, 3, 0); new_test(2, 3); rdy_mode = 0;
    repeat (3) step();
    expect1("clear_busy_before", busy_o, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    expect1("clear_valid", m_valid_o, 0);
    expect1("clear_busy", busy_o, 0);
    tag_base = 0;
    new_test(1, 3); rdy_mode = 2;
    check_pairs("after_clear", 1, 3);
  endtask

  task automatic test_tag_wrap();
    new_test(1, 0); rdy_mode = 1;
    step(); step();
    cfg(0, 1, 1);
    expect1("clear_load_rej", cfg_rej_o, 0);
    expect1("clear_load_busy", busy_o, 0);
    new_test(5, 5); rdy_mode = 1;
    check_pairs("tag_wrap", 0, 1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; rdy_mode = 1;
    test_reset();
    test_one2one();
    test_a_reuse();
    test_b_reuse();
    test_backpressure();
    test_cfg_reject();
    test_clear();
    test_tag_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
